// File: rtl/adc_scan_sched.sv
// Round-robin arbiter and sequencer that shares one MCP3008 SPI engine between NREQ requesters.
// Define AUTO_SCAN_EN to add background scanning of all 8 channels into the sample bank.
module adc_scan_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_chan,
  input  logic [NREQ-1:0]   req_diff,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  output logic [9:0]        rsp_data,
  output logic              spi_start,
  output logic              spi_single,
  output logic [2:0]        spi_chan,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [9:0]        spi_data,
  output logic [79:0]       bank_data,
  output logic [7:0]        bank_valid
);
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [2:0]      chan_q, chan_d;
  logic            single_q, single_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
  logic [9:0]      rsp_data_q, rsp_data_d;
  logic [79:0]     bank_q, bank_d;
  logic [7:0]      bank_valid_q, bank_valid_d;

`ifdef AUTO_SCAN_EN
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]       scan_chan_q, scan_chan_d;
  logic             scan_act_q, scan_act_d;
`endif

  logic            win_found;
  logic [PtrW-1:0] win_idx;
  logic [NREQ-1:0] win_oh;

  // Circular search for the first requester at or after the pointer.
  always_comb begin : rr_search
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = (int'(ptr_q) + i) % int'(NREQ);
      if (!win_found && req[idx]) begin
        win_found   = 1'b1;
        win_idx     = PtrW'(idx);
        win_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    chan_d       = chan_q;
    single_d     = single_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = '0;
    rsp_err_d    = 1'b0;
    rsp_data_d   = rsp_data_q;
    bank_d       = bank_q;
    bank_valid_d = bank_valid_q;
    spi_start    = 1'b0;
`ifdef AUTO_SCAN_EN
    scan_cnt_d   = '0;
    scan_chan_d  = scan_chan_q;
    scan_act_d   = scan_act_q;
`endif
    case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d  = win_oh;
          chan_d   = req_chan[3*win_idx +: 3];
          single_d = ~req_diff[win_idx];
          ptr_d    = (win_idx == PtrW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_d  = StIssue;
        end
`ifdef AUTO_SCAN_EN
        else if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
          // Internal conversion: no owner, so no response strobe later.
          grant_d    = '0;
          chan_d     = scan_chan_q;
          single_d   = 1'b1;
          scan_act_d = 1'b1;
          state_d    = StIssue;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
`endif
      end
      StIssue: begin
        if (!spi_busy) begin
          spi_start = 1'b1;
          cnt_d     = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (spi_done) begin
          rsp_data_d  = spi_data;
          rsp_valid_d = grant_q;
          state_d     = StDone;
        end else if (cnt_d == CntW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = grant_q;
          state_d     = StDone;
        end
      end
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
        if (!rsp_err_q) begin
          bank_d[10*chan_q +: 10] = rsp_data_q;
          bank_valid_d[chan_q]    = 1'b1;
        end
`ifdef AUTO_SCAN_EN
        if (scan_act_q) begin
          scan_act_d  = 1'b0;
          scan_chan_d = scan_chan_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      ptr_q        <= '0;
      chan_q       <= '0;
      single_q     <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      bank_q       <= '0;
      bank_valid_q <= '0;
`ifdef AUTO_SCAN_EN
      scan_cnt_q   <= '0;
      scan_chan_q  <= '0;
      scan_act_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      chan_q       <= chan_d;
      single_q     <= single_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      bank_q       <= bank_d;
      bank_valid_q <= bank_valid_d;
`ifdef AUTO_SCAN_EN
      scan_cnt_q   <= scan_cnt_d;
      scan_chan_q  <= scan_chan_d;
      scan_act_q   <= scan_act_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign spi_single = single_q;
  assign spi_chan   = chan_q;
  assign bank_data  = bank_q;
  assign bank_valid = bank_valid_q;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed self-checking bench for adc_scan_sched with NREQ=4, TIMEOUT=64, SCAN_DIV=16.
module tb_adc_scan_sched;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned SCAN_DIV = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_chan;
  logic [NREQ-1:0]   req_diff;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_err;
  logic [9:0]        rsp_data;
  logic              spi_start;
  logic              spi_single;
  logic [2:0]        spi_chan;
  logic              spi_busy;
  logic              spi_done;
  logic [9:0]        spi_data;
  logic [79:0]       bank_data;
  logic [7:0]        bank_valid;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  adc_scan_sched #(
    .NREQ     (NREQ),
    .TIMEOUT  (TIMEOUT),
    .SCAN_DIV (SCAN_DIV)
  ) u_dut (
    .clk        (clk),
    .rst        (rst_n),
    .req        (req),
    .req_chan   (req_chan),
    .req_diff   (req_diff),
    .grant      (grant),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_data   (rsp_data),
    .spi_start  (spi_start),
    .spi_single (spi_single),
    .spi_chan   (spi_chan),
    .spi_busy   (spi_busy),
    .spi_done   (spi_done),
    .spi_data   (spi_data),
    .bank_data  (bank_data),
    .bank_valid (bank_valid)
  );

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant == '0 && k < 20);
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (!spi_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_start"}, 80'(spi_start), 80'd1);
  endtask

  // One requester transaction; returns on the negedge of the response cycle.
  task automatic run_txn(input string tag, input logic [3:0] exp_grant, input logic [2:0] exp_chan,
                         input logic exp_single, input int dly, input logic [9:0] data);
    wait_grant();
    check_val({tag, "_grant"}, 80'(grant), 80'(exp_grant));
    check_val({tag, "_chan"}, 80'(spi_chan), 80'(exp_chan));
    check_val({tag, "_single"}, 80'(spi_single), 80'(exp_single));
    wait_start(tag);
    repeat (dly) @(negedge clk);
    spi_done = 1'b1;
    spi_data = data;
    @(negedge clk);
    spi_done = 1'b0;
    check_val({tag, "_rsp_valid"}, 80'(rsp_valid), 80'(exp_grant));
    check_val({tag, "_rsp_err"}, 80'(rsp_err), 80'd0);
    check_val({tag, "_rsp_data"}, 80'(rsp_data), 80'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic seen;
    rst_n    = 1'b1;
    req      = '0;
    req_chan = '0;
    req_diff = '0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_data = '0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_grant", 80'(grant), 80'd0);
    check_val("rst_rsp_valid", 80'(rsp_valid), 80'd0);
    check_val("rst_rsp_err", 80'(rsp_err), 80'd0);
    check_val("rst_rsp_data", 80'(rsp_data), 80'd0);
    check_val("rst_spi_start", 80'(spi_start), 80'd0);
    check_val("rst_spi_single", 80'(spi_single), 80'd0);
    check_val("rst_spi_chan", 80'(spi_chan), 80'd0);
    check_val("rst_bank_data", bank_data, 80'd0);
    check_val("rst_bank_valid", 80'(bank_valid), 80'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-ended ch5 conversion for requester 0.
    req      = 4'b0001;
    req_chan = 12'd5;
    req_diff = 4'b0000;
    run_txn("t1", 4'b0001, 3'd5, 1'b1, 20, 10'h2A7);
    req = '0;
    @(negedge clk);
    check_val("t1_bank_ch5", 80'(bank_data[59:50]), 80'h2A7);
    check_val("t1_bank_valid", 80'(bank_valid), 80'h20);
    check_val("t1_grant_clear", 80'(grant), 80'd0);

    // Round robin from pointer 0 with all four requesting.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    req      = 4'b1111;
    req_chan = {3'd4, 3'd3, 3'd2, 3'd1};
    req_diff = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      run_txn($sformatf("rr%0d", i), 4'(1 << i), 3'(i + 1), (i % 2) == 0, 3 + i,
              10'(32'h100 + i));
    end
    req = '0;
    @(negedge clk);
    check_val("rr_bank_valid", 80'(bank_valid), 80'h1E);
    check_val("rr_bank_ch3", 80'(bank_data[39:30]), 80'h102);

    // Timeout: no spi_done at all.
    req      = 4'b0100;
    req_chan = {3'd0, 3'd6, 3'd0, 3'd0};
    req_diff = 4'b0000;
    wait_grant();
    check_val("to_grant", 80'(grant), 80'b0100);
    wait_start("to");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid[2] && k < 80);
    req = '0;
    check_val("to_latency", 80'(k), 80'(TIMEOUT));
    check_val("to_rsp_valid", 80'(rsp_valid), 80'b0100);
    check_val("to_rsp_err", 80'(rsp_err), 80'd1);
    check_val("to_rsp_data", 80'(rsp_data), 80'd0);
    @(negedge clk);
    check_val("to_bank_valid", 80'(bank_valid), 80'h1E);
    check_val("to_bank_ch6", 80'(bank_data[69:60]), 80'd0);

    // spi_done on the expiry cycle wins.
    req = 4'b0100;
    wait_grant();
    check_val("ex_grant", 80'(grant), 80'b0100);
    wait_start("ex");
    repeat (TIMEOUT - 1) @(negedge clk);
    spi_done = 1'b1;
    spi_data = 10'h155;
    @(negedge clk);
    spi_done = 1'b0;
    req      = '0;
    check_val("ex_rsp_valid", 80'(rsp_valid), 80'b0100);
    check_val("ex_rsp_err", 80'(rsp_err), 80'd0);
    check_val("ex_rsp_data", 80'(rsp_data), 80'h155);
    @(negedge clk);
    check_val("ex_bank_valid", 80'(bank_valid), 80'h5E);
    check_val("ex_bank_ch6", 80'(bank_data[69:60]), 80'h155);

    // Engine busy for 10 cycles in ISSUE; a stray spi_done there is ignored.
    spi_busy = 1'b1;
    req      = 4'b0001;
    req_chan = 12'd7;
    wait_grant();
    check_val("bz_grant", 80'(grant), 80'b0001);
    seen = spi_start;
    for (int i = 0; i < 10; i++) begin
      spi_done = (i == 4);
      @(negedge clk);
      seen = seen | spi_start | (|rsp_valid);
    end
    spi_done = 1'b0;
    check_val("bz_held", 80'(seen), 80'd0);
    spi_busy = 1'b0;
    #1;
    check_val("bz_start", 80'(spi_start), 80'd1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid[0] && k < 80);
    req = '0;
    check_val("bz_latency", 80'(k), 80'(TIMEOUT));
    check_val("bz_rsp_err", 80'(rsp_err), 80'd1);

    // Reset in WAIT abandons the transaction and the pointer.
    @(negedge clk);
    req      = 4'b0010;
    req_chan = {3'd0, 3'd0, 3'd2, 3'd4};
    wait_grant();
    check_val("rw_grant", 80'(grant), 80'b0010);
    wait_start("rw");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rw_grant_rst", 80'(grant), 80'd0);
    check_val("rw_chan_rst", 80'(spi_chan), 80'd0);
    check_val("rw_bank_valid_rst", 80'(bank_valid), 80'd0);
    check_val("rw_bank_data_rst", bank_data, 80'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    spi_done = 1'b1;
    spi_data = 10'h3FF;
    @(negedge clk);
    spi_done = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | (|rsp_valid) | (|grant);
    end
    check_val("rw_stray_done", 80'(seen), 80'd0);
    check_val("rw_bank_after", 80'(bank_valid), 80'd0);
    req = 4'b1111;
    run_txn("rw_ptr0", 4'b0001, 3'd4, 1'b1, 2, 10'h0AB);
    req = '0;

`ifdef AUTO_SCAN_EN
    // Background scan of ch0..7, then a requester arriving on the trigger cycle.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_start($sformatf("sc%0d", i));
      check_val($sformatf("sc%0d_grant", i), 80'(grant), 80'd0);
      check_val($sformatf("sc%0d_chan", i), 80'(spi_chan), 80'(i));
      check_val($sformatf("sc%0d_single", i), 80'(spi_single), 80'd1);
      repeat (2) @(negedge clk);
      spi_done = 1'b1;
      spi_data = 10'(32'h40 + i);
      @(negedge clk);
      spi_done = 1'b0;
      check_val($sformatf("sc%0d_rsp_valid", i), 80'(rsp_valid), 80'd0);
    end
    @(negedge clk);
    check_val("sc_bank_valid", 80'(bank_valid), 80'hFF);
    check_val("sc_bank_ch7", 80'(bank_data[79:70]), 80'h47);
    repeat (SCAN_DIV - 1) @(negedge clk);
    req      = 4'b0001;
    req_chan = 12'd3;
    req_diff = 4'b0001;
    run_txn("sc_defer", 4'b0001, 3'd3, 1'b0, 2, 10'h1C3);
    req = '0;
    wait_start("sc_resume");
    check_val("sc_resume_grant", 80'(grant), 80'd0);
    check_val("sc_resume_chan", 80'(spi_chan), 80'd0);
    @(negedge clk);
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/adc_scan_sched.md
Name: adc_scan_sched

Overview:
- Arbiter and sequencer in front of the SPI ADC transaction engine for the MCP3008-class 8-channel 10-bit converter.
- Shares the single engine between NREQ requesters (motor, battery and sensor logic) with round-robin grants.
- Issues the start/single/channel command and waits for completion with a timeout.
- Returns the 10-bit result to the winning requester and keeps a per-channel latest-sample bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles from spi_start to spi_done before abort.
- SCAN_DIV, 1024, idle cycles between automatic scan conversions (AUTO_SCAN_EN only).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous reset, active-low.
- req  in  NREQ  per-requester conversion request, level, held until response.
- req_chan  in  3*NREQ  channel select, requester i at bits [3i+2:3i].
- req_diff  in  NREQ  1 = differential, 0 = single-ended.
- grant  out  NREQ  one-hot owner of the current transaction.
- rsp_valid  out  NREQ  one-hot, 1-cycle response strobe to the owner.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout.
- rsp_data  out  10  conversion result, valid with rsp_valid.
- spi_start  out  1  1-cycle command strobe to the SPI engine.
- spi_single  out  1  Single/Diff bit to the engine (= ~req_diff of owner).
- spi_chan  out  3  D2..D0 channel bits to the engine.
- spi_busy  in  1  engine busy; no spi_start while high.
- spi_done  in  1  1-cycle completion strobe from the engine.
- spi_data  in  10  engine result, valid with spi_done.
- bank_data  out  80  latest sample per channel, channel c at [10c+9:10c].
- bank_valid  out  8  channel c has at least one good sample since reset.

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - grant, rsp_valid, rsp_err, rsp_data, spi_start, spi_single, spi_chan, bank_data, bank_valid all 0.
  - RR pointer = 0; timeout counter = 0.
  - Reset mid-transaction abandons it silently; no rsp_valid is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the pointer, searching circularly.
  - grant is registered; spi_chan, spi_single and the command are latched from the winner.
  - Next state ISSUE; pointer <- (winner+1) mod NREQ.
- ISSUE:
  - If spi_busy = 0, drive spi_start = 1 for exactly this cycle, clear the timeout counter, next state WAIT.
  - Otherwise hold in ISSUE with no timeout counting.
- WAIT:
  - Counter increments each cycle.
  - On spi_done: latch spi_data, next state DONE with err = 0.
  - Else if counter reaches TIMEOUT-1: rsp_data <- 0, next state DONE with err = 1.
  - spi_done on the same cycle as expiry wins; err = 0.
- DONE (1 cycle):
  - rsp_valid = grant and rsp_err = err, both for one cycle.
  - If err = 0, bank[chan] <- data and bank_valid[chan] <- 1.
  - grant clears at the exit edge; next state IDLE.
- Latency: req seen in IDLE at cycle N -> spi_start at N+1 (engine idle) -> rsp_valid one cycle after the spi_done cycle.
- Minimum IDLE dwell is 1 cycle between transactions.
- spi_done outside WAIT is ignored.
- Requesters deasserting req after grant do not cancel; the response is still issued.
- req_chan/req_diff changes after grant are ignored.
- Command fields (spi_chan, spi_single) hold stable from ISSUE through DONE.

Optional Feature:
- Macro: AUTO_SCAN_EN.
- With the macro:
  - A scan counter runs only in IDLE with req == 0; it clears on leaving IDLE or when any req is seen.
  - When the counter reaches SCAN_DIV-1, start an internal single-ended transaction on scan_chan with grant = 0.
  - The internal transaction issues no rsp_valid and updates the bank on success.
  - scan_chan increments mod 8 after every scan attempt, including timeouts.
  - A requester asserting req on the trigger cycle takes priority; the scan is deferred.
- Without the macro: no scan logic; the bank is updated only by requester transactions.

Test Plan:
- req = 0001, chan0 = 5, single, spi_busy = 0, engine returns 0x2A7 after 20 cycles -> spi_chan = 5, spi_single = 1, rsp_valid = 0001, rsp_data = 0x2A7, bank ch5 = 0x2A7, bank_valid = 0x20.
- req = 1111 held for 4 transactions, pointer starting at 0 -> grants 0001, 0010, 0100, 1000 in order, each grant one-hot and never overlapping.
- No spi_done after spi_start -> rsp_valid with rsp_err = 1, rsp_data = 0 exactly TIMEOUT cycles after spi_start, bank unchanged; spi_done arriving on the expiry cycle -> err = 0.
- spi_busy held high for 10 cycles while in ISSUE -> spi_start delayed until the first cycle busy = 0; no timeout is counted in ISSUE.
- rst pulsed low during WAIT -> all outputs 0 immediately; a later spi_done is ignored; next req is granted starting from pointer 0.
- AUTO_SCAN_EN, SCAN_DIV = 16, no req -> scans ch0..7 every 16+ cycles and bank_valid reaches 0xFF; req asserted on a trigger cycle -> requester served first.
